// File: rtl/mod_pkg.sv
// Shared mode encodings, symbol sizing and default constellation
// amplitudes for the symbol mapper.
package mod_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK    = 2'd0,
    MODE_PI2BPSK = 2'd1,
    MODE_QPSK    = 2'd2,
    MODE_QAM16   = 2'd3
  } mode_e;

  localparam int DEF_W        = 16;
  localparam int DEF_AMP_ONE  = 32767;
  localparam int DEF_AMP_QPSK = 23171;
  localparam int DEF_AMP_LO   = 10362;
  localparam int DEF_AMP_HI   = 31086;

  function automatic logic [2:0] bps(input mode_e m);
    unique case (m)
      MODE_QPSK:  bps = 3'd2;
      MODE_QAM16: bps = 3'd4;
      default:    bps = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mod_point_map.sv
// Combinational constellation lookup: (mode, bits, phase) -> (I, Q).
// Bit b0 sits in bits[0]; a 0 bit maps to the negative amplitude.
module mod_point_map
  import mod_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int AMP_ONE  = DEF_AMP_ONE,
  parameter int AMP_QPSK = DEF_AMP_QPSK,
  parameter int AMP_LO   = DEF_AMP_LO,
  parameter int AMP_HI   = DEF_AMP_HI
) (
  input  mode_e        mode,
  input  logic [3:0]   bits,
  input  logic         phase,
  output logic [W-1:0] i_out,
  output logic [W-1:0] q_out
);

  localparam int LIM = 2 ** (W - 1);

  if (AMP_ONE >= LIM || AMP_QPSK >= LIM ||
      AMP_LO >= LIM || AMP_HI >= LIM) begin : g_amp_chk
    $error("mod_point_map: amplitude does not fit signed W bits");
  end

  localparam logic [W-1:0] A_ONE = W'(AMP_ONE);
  localparam logic [W-1:0] A_QP  = W'(AMP_QPSK);
  localparam logic [W-1:0] A_LO  = W'(AMP_LO);
  localparam logic [W-1:0] A_HI  = W'(AMP_HI);

  function automatic logic [W-1:0] sgn(
    input logic         b,
    input logic [W-1:0] a
  );
    return b ? a : (~a + 1'b1);
  endfunction

  always_comb begin
    i_out = '0;
    q_out = '0;
    unique case (1'b1)
      mode == MODE_BPSK: begin
        i_out = sgn(bits[0], A_ONE);
      end
      mode == MODE_PI2BPSK: begin
        // odd phase rotates by 90 degrees: I picks up a sign flip
        i_out = sgn(bits[0] ^ phase, A_QP);
        q_out = sgn(bits[0], A_QP);
      end
      mode == MODE_QPSK: begin
        i_out = sgn(bits[0], A_QP);
        q_out = sgn(bits[1], A_QP);
      end
      mode == MODE_QAM16: begin
        i_out = sgn(bits[0], bits[2] ? A_HI : A_LO);
        q_out = sgn(bits[1], bits[3] ? A_HI : A_LO);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/symbol_mapper.sv
// Serial-bit to I/Q symbol mapper: gathers 1/2/4 bits per symbol,
// maps them and presents one registered point over valid/ready.
module symbol_mapper
  import mod_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int AMP_ONE  = DEF_AMP_ONE,
  parameter int AMP_QPSK = DEF_AMP_QPSK,
  parameter int AMP_LO   = DEF_AMP_LO,
  parameter int AMP_HI   = DEF_AMP_HI
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tdata,
  input  logic         s_tlast,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_real,
  output logic [W-1:0] m_imag,
  output logic         m_tlast
);

  logic [1:0]   cnt_q, cnt_d;
  logic [3:0]   buf_q, buf_d;
  logic         phase_q, phase_d;
  mode_e        mode_q, mode_d;
  logic         m_tvalid_q, m_tvalid_d;
  logic [W-1:0] m_real_q, m_real_d;
  logic [W-1:0] m_imag_q, m_imag_d;
  logic         m_tlast_q, m_tlast_d;

  logic         first, acc, done, phase_eff;
  mode_e        mode_eff;
  logic [3:0]   bits_w;
  logic [W-1:0] pt_i, pt_q;

  assign s_tready = !m_tvalid_q | m_tready;
  assign m_tvalid = m_tvalid_q;
  assign m_real   = m_real_q;
  assign m_imag   = m_imag_q;
  assign m_tlast  = m_tlast_q;

  always_comb begin
    first     = cnt_q == 2'd0;
    acc       = s_tvalid & s_tready;
    mode_eff  = first ? mode_e'(mode) : mode_q;
    // a new latched mode restarts the pi/2 rotation
    phase_eff = (first && mode_eff != mode_q) ? 1'b0 : phase_q;
    bits_w         = buf_q;
    bits_w[cnt_q]  = s_tdata;
    done = acc &
           (({1'b0, cnt_q} == bps(mode_eff) - 3'd1) | s_tlast);
  end

  mod_point_map #(
    .W(W), .AMP_ONE(AMP_ONE), .AMP_QPSK(AMP_QPSK),
    .AMP_LO(AMP_LO), .AMP_HI(AMP_HI)
  ) u_map (
    .mode (mode_eff),
    .bits (bits_w),
    .phase(phase_eff),
    .i_out(pt_i),
    .q_out(pt_q)
  );

  always_comb begin
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    m_tvalid_d = m_tvalid_q & ~m_tready;
    m_real_d   = m_real_q;
    m_imag_d   = m_imag_q;
    m_tlast_d  = m_tlast_q;
    if (acc) begin
      cnt_d   = cnt_q + 2'd1;
      buf_d   = bits_w;
      mode_d  = mode_eff;
      phase_d = phase_eff;
    end
    if (done) begin
      cnt_d      = 2'd0;
      buf_d      = 4'd0;
      phase_d    = s_tlast ? 1'b0 : ~phase_eff;
      m_tvalid_d = 1'b1;
      m_real_d   = pt_i;
      m_imag_d   = pt_q;
      m_tlast_d  = s_tlast;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      buf_q      <= 4'd0;
      phase_q    <= 1'b0;
      mode_q     <= MODE_BPSK;
      m_tvalid_q <= 1'b0;
      m_real_q   <= '0;
      m_imag_q   <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      m_tvalid_q <= m_tvalid_d;
      m_real_q   <= m_real_d;
      m_imag_q   <= m_imag_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

endmodule
